// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the DSP-slice MAC sequencer.
package dsp_mac_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DRAIN,
      OUTPUT
   } state_t;

   // Slice opmode: bit 0 selects X=M, bit 3 selects Z=P
   localparam logic [7:0] OPM_CLEAR = 8'h00;
   localparam logic [7:0] OPM_FIRST = 8'h01;
   localparam logic [7:0] OPM_ACC   = 8'h09;
   localparam logic [7:0] OPM_HOLD  = 8'h08;

   localparam int PIPE_LAT_DEFAULT = 2;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// Streams (a, b) beats into a DSP slice as a MAC and returns the dot product.
// Optional MAC_SAT_EN clamps the result to OUT_W signed bits and adds m_sat.
module dsp_mac_sequencer
   import dsp_mac_pkg::*;
#(
   parameter int PIPE_LAT = PIPE_LAT_DEFAULT,
   parameter int CNT_W    = 8,
   parameter int OUT_W    = 32
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [17:0]      s_a,
   input  logic [17:0]      s_b,
   input  logic             s_last,
   output logic [17:0]      dsp_A,
   output logic [17:0]      dsp_B,
   output logic [7:0]       dsp_opmode,
   input  logic [47:0]      dsp_P,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [47:0]      m_data,
   output logic [CNT_W-1:0] m_count
`ifdef MAC_SAT_EN
   ,
   output logic             m_sat
`endif
);

   localparam int              DRAIN_W = $clog2(PIPE_LAT + 2);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t             r_state;
   state_t             w_state_nxt;
   logic               w_accept;
   logic               w_capture;
   logic [17:0]        w_a_nxt;
   logic [17:0]        w_b_nxt;
   logic [7:0]         w_opm_nxt;
   logic [CNT_W-1:0]   r_beat_cnt;
   logic [DRAIN_W-1:0] r_drain_cnt;
   logic [47:0]        w_result;

   assign w_accept  = s_valid && s_ready;
   // P reflects the last beat PIPE_LAT clocks after it left this block
   assign w_capture = (r_state == DRAIN) && (r_drain_cnt == DRAIN_W'(PIPE_LAT));

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or posedge RST) begin
      if (RST) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: default every always_comb output first so no path infers a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE, ACCUM: if (w_accept) w_state_nxt = s_last ? DRAIN : ACCUM;
         DRAIN:       if (w_capture) w_state_nxt = OUTPUT;
         OUTPUT:      if (m_valid && m_ready) w_state_nxt = IDLE;
         default:     w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s_ready   = 1'b0;
      w_a_nxt   = '0;
      w_b_nxt   = '0;
      w_opm_nxt = OPM_HOLD;
      case (r_state)
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               w_a_nxt   = s_a;
               w_b_nxt   = s_b;
               w_opm_nxt = OPM_FIRST;
            end
         end
         ACCUM: begin
            s_ready = 1'b1;
            if (s_valid) begin
               w_a_nxt   = s_a;
               w_b_nxt   = s_b;
               w_opm_nxt = OPM_ACC;
            end
         end
         default: ;
      endcase
   end

`ifdef MAC_SAT_EN
   localparam logic signed [47:0] SAT_MAX = (48'sd1 <<< (OUT_W - 1)) - 48'sd1;
   localparam logic signed [47:0] SAT_MIN = -(48'sd1 <<< (OUT_W - 1));

   logic signed [47:0] w_p_s;
   logic               w_sat;

   assign w_p_s = signed'(dsp_P);

   always_comb begin
      w_result = dsp_P;
      w_sat    = 1'b0;
      if (w_p_s > SAT_MAX) begin
         w_result = SAT_MAX;
         w_sat    = 1'b1;
      end else if (w_p_s < SAT_MIN) begin
         w_result = SAT_MIN;
         w_sat    = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST)            m_sat <= 1'b0;
      else if (w_capture) m_sat <= w_sat;
   end
`else
   assign w_result = dsp_P;
`endif

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         dsp_A       <= '0;
         dsp_B       <= '0;
         dsp_opmode  <= OPM_CLEAR;
         r_beat_cnt  <= '0;
         r_drain_cnt <= '0;
         m_valid     <= 1'b0;
         m_data      <= '0;
         m_count     <= '0;
      end else begin
         dsp_A      <= w_a_nxt;
         dsp_B      <= w_b_nxt;
         dsp_opmode <= w_opm_nxt;

         if (w_accept) begin
            if (r_state == IDLE)          r_beat_cnt <= CNT_W'(1);
            else if (r_beat_cnt != CNT_MAX) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
         end

         if (r_state != DRAIN) r_drain_cnt <= '0;
         else if (!w_capture)  r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);

         if (w_capture) begin
            m_valid <= 1'b1;
            m_data  <= w_result;
            m_count <= r_beat_cnt;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer driving a behavioural MAC slice (A1/B1/OPMODE/P regs).
module tb_dsp_mac_sequencer;
   import dsp_mac_pkg::*;

`ifdef MAC_SAT_EN
   localparam int TB_OUT_W = 16;
`else
   localparam int TB_OUT_W = 32;
`endif

   logic        clk = 1'b0;
   logic        RST;
   logic        s_valid;
   logic        s_ready;
   logic [17:0] s_a;
   logic [17:0] s_b;
   logic        s_last;
   logic [17:0] dsp_A;
   logic [17:0] dsp_B;
   logic [7:0]  dsp_opmode;
   logic [47:0] dsp_P;
   logic        m_valid;
   logic        m_ready;
   logic [47:0] m_data;
   logic [7:0]  m_count;
`ifdef MAC_SAT_EN
   logic        m_sat;
`endif

   int n_applied = 0;
   int n_miss    = 0;

   always #5 clk = ~clk;

   dsp_mac_sequencer #(
      .PIPE_LAT (2),
      .CNT_W    (8),
      .OUT_W    (TB_OUT_W)
   ) dut (
      .clk        (clk),
      .RST        (RST),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_a        (s_a),
      .s_b        (s_b),
      .s_last     (s_last),
      .dsp_A      (dsp_A),
      .dsp_B      (dsp_B),
      .dsp_opmode (dsp_opmode),
      .dsp_P      (dsp_P),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_count    (m_count)
`ifdef MAC_SAT_EN
      ,
      .m_sat      (m_sat)
`endif
   );

   // Slice model: A1, B1, OPMODE registered, unregistered product, PREG=1
   logic signed [17:0] sl_a1  = '0;
   logic signed [17:0] sl_b1  = '0;
   logic [7:0]         sl_opm = '0;
   logic [47:0]        sl_p   = '0;
   logic signed [47:0] sl_ax;
   logic signed [47:0] sl_bx;
   logic signed [47:0] sl_m;

   assign sl_ax = sl_a1;
   assign sl_bx = sl_b1;
   assign sl_m  = sl_ax * sl_bx;
   assign dsp_P = sl_p;

   always @(posedge clk) begin
      sl_a1  <= dsp_A;
      sl_b1  <= dsp_B;
      sl_opm <= dsp_opmode;
      sl_p   <= (sl_opm[0] ? sl_m : 48'd0) + (sl_opm[3] ? sl_p : 48'd0);
   end

   typedef struct {
      int            n;
      logic [17:0]   a [3];
      logic [17:0]   b [3];
      int            gap;
      int            hold;
      logic [47:0]   exp_raw;
      int            exp_cnt;
   } vec_t;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_applied++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [47:0] exp_data(input logic signed [47:0] raw);
`ifdef MAC_SAT_EN
      if (raw > 48'sd32767)  return 48'sd32767;
      if (raw < -48'sd32768) return -48'sd32768;
`endif
      return raw;
   endfunction

   function automatic logic exp_sat(input logic signed [47:0] raw);
      return (raw > 48'sd32767) || (raw < -48'sd32768);
   endfunction

   function automatic vec_t mk(input int n, input int a0, input int b0, input int a1,
                               input int b1, input int a2, input int b2, input int gap,
                               input int hold, input longint raw, input int cnt);
      vec_t v;
      v.n = n;
      v.a[0] = 18'(a0); v.b[0] = 18'(b0);
      v.a[1] = 18'(a1); v.b[1] = 18'(b1);
      v.a[2] = 18'(a2); v.b[2] = 18'(b2);
      v.gap = gap;
      v.hold = hold;
      v.exp_raw = 48'(raw);
      v.exp_cnt = cnt;
      return v;
   endfunction

   // Called at a negedge; returns at the negedge following the accept edge
   task automatic send_beat(input logic [17:0] a, input logic [17:0] b, input logic last,
                            input logic first, input int gap);
      int w = 0;
      s_valid = 1'b1;
      s_a     = a;
      s_b     = b;
      s_last  = last;
      while (!s_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (w >= 20) check("s_ready_timeout", 48'(s_ready), 48'd1);
      @(posedge clk);
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
      check("beat_dsp_A", 48'(dsp_A), 48'(a));
      check("beat_dsp_B", 48'(dsp_B), 48'(b));
      check("beat_opmode", 48'(dsp_opmode), first ? 48'h01 : 48'h09);
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         check("bubble_opmode", 48'(dsp_opmode), 48'h08);
         check("bubble_dsp_A", 48'(dsp_A), 48'd0);
      end
   endtask

   // Called at the negedge right after the last beat's accept edge e
   task automatic finish_vec(input logic [47:0] raw, input int cnt, input int hold);
      check("drain_s_ready", 48'(s_ready), 48'd0);
      @(negedge clk);
      check("e1_m_valid", 48'(m_valid), 48'd0);
      check("e1_opmode", 48'(dsp_opmode), 48'h08);
      @(negedge clk);
      check("e2_m_valid", 48'(m_valid), 48'd0);
      @(negedge clk);
      check("e3_m_valid", 48'(m_valid), 48'd1);
      check("m_data", m_data, exp_data(raw));
      check("m_count", 48'(m_count), 48'(cnt));
`ifdef MAC_SAT_EN
      check("m_sat", 48'(m_sat), 48'(exp_sat(raw)));
`endif
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check("hold_m_valid", 48'(m_valid), 48'd1);
         check("hold_m_data", m_data, exp_data(raw));
         check("hold_m_count", 48'(m_count), 48'(cnt));
         check("hold_s_ready", 48'(s_ready), 48'd0);
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
      check("post_m_valid", 48'(m_valid), 48'd0);
      check("post_s_ready", 48'(s_ready), 48'd1);
   endtask

   task automatic run_vec(input vec_t v);
      for (int i = 0; i < v.n; i++)
         send_beat(v.a[i], v.b[i], (i == v.n - 1), (i == 0), (i == v.n - 1) ? 0 : v.gap);
      finish_vec(v.exp_raw, v.exp_cnt, v.hold);
   endtask

   vec_t tbl [8];

   initial begin
      tbl[0] = mk(3,       3,       4, 5, 6, 7, 8, 0, 0, 98, 3);
      tbl[1] = mk(1,       2,       9, 0, 0, 0, 0, 0, 0, 18, 1);
      tbl[2] = mk(3,       3,       4, 5, 6, 7, 8, 2, 0, 98, 3);
      tbl[3] = mk(3,       3,       4, 5, 6, 7, 8, 0, 5, 98, 3);
      tbl[4] = mk(1,       1,       1, 0, 0, 0, 0, 0, 0, 1, 1);
      tbl[5] = mk(2,      -3,       5, 2, 2, 0, 0, 1, 0, -11, 2);
      tbl[6] = mk(1,  131071,  131071, 0, 0, 0, 0, 0, 0, 64'h3_FFFC_0001, 1);
      tbl[7] = mk(2, -131072, -131072, -1, 1, 0, 0, 0, 0, 64'h3_FFFF_FFFF, 2);

      RST     = 1'b1;
      s_valid = 1'b0;
      s_a     = '0;
      s_b     = '0;
      s_last  = 1'b0;
      m_ready = 1'b0;
      #3;
      check("rst_s_ready", 48'(s_ready), 48'd1);
      check("rst_dsp_A", 48'(dsp_A), 48'd0);
      check("rst_dsp_B", 48'(dsp_B), 48'd0);
      check("rst_opmode", 48'(dsp_opmode), 48'h00);
      check("rst_m_valid", 48'(m_valid), 48'd0);
      check("rst_m_data", m_data, 48'd0);
      check("rst_m_count", 48'(m_count), 48'd0);
      repeat (3) @(negedge clk);
      RST = 1'b0;
      @(negedge clk);
      check("idle_opmode", 48'(dsp_opmode), 48'h08);

      for (int t = 0; t < 8; t++) run_vec(tbl[t]);

      // Beat counter saturates at 255 while P keeps accumulating
      for (int i = 0; i < 300; i++) send_beat(18'd1, 18'd1, (i == 299), (i == 0), 0);
      finish_vec(48'd300, 255, 0);

      // Reset in mid-vector abandons it immediately
      send_beat(18'd3, 18'd4, 1'b0, 1'b1, 0);
      send_beat(18'd5, 18'd6, 1'b0, 1'b0, 0);
      RST = 1'b1;
      #1;
      check("mid_rst_dsp_A", 48'(dsp_A), 48'd0);
      check("mid_rst_dsp_B", 48'(dsp_B), 48'd0);
      check("mid_rst_opmode", 48'(dsp_opmode), 48'h00);
      check("mid_rst_m_valid", 48'(m_valid), 48'd0);
      check("mid_rst_m_data", m_data, 48'd0);
      check("mid_rst_m_count", 48'(m_count), 48'd0);
      check("mid_rst_s_ready", 48'(s_ready), 48'd1);
      repeat (3) @(negedge clk);
      check("in_rst_m_valid", 48'(m_valid), 48'd0);
      RST = 1'b0;
      @(negedge clk);
      send_beat(18'd4, 18'd5, 1'b1, 1'b1, 0);
      finish_vec(48'd20, 1, 0);

`ifdef MAC_SAT_EN
      send_beat(18'd255, 18'd255, 1'b0, 1'b1, 0);
      send_beat(18'd255, 18'd255, 1'b1, 1'b0, 0);
      finish_vec(48'd130050, 2, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
      $finish;
   end

endmodule
